ex_mem_latch: RTL and testbench
===============================

Name: ex_mem_latch

Overview:
- EX/MEM pipeline register of the MIPS core.
- Sits directly downstream of the EX stage: the destination register selector (rt / rd / 31 per sel_reg encoding 00/10/01) and the ALU.
- Captures the destination register number, ALU result, store data, link address and MEM/WB control every clock.
- Supports stall (hold) and flush (bubble insertion) from the hazard unit.

Parameters:
- NBITS, 32, data/address width.
- RBITS, 5, register-number width.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- i_stall  input  1  hold all outputs this cycle.
- i_flush  input  1  load a bubble this cycle.
- i_valid  input  1  EX stage holds a real instruction.
- i_write_reg  input  RBITS  destination register from EX destination mux.
- i_alu_result  input  NBITS  ALU result / memory address.
- i_store_data  input  NBITS  forwarded rt value for stores.
- i_pc_plus8  input  NBITS  link address for JAL/JALR.
- i_reg_write  input  1  instruction writes register file.
- i_mem_read  input  1  load.
- i_mem_write  input  1  store.
- i_mem_to_reg  input  2  WB source: 00 ALU, 01 memory, 10 link.
- i_mem_width  input  2  00 byte, 01 half, 11 word.
- i_mem_unsigned  input  1  zero-extend loads.
- i_halt  input  1  HALT instruction.
- o_valid  output  1  MEM stage holds a real instruction.
- o_write_reg  output  RBITS  latched destination register.
- o_alu_result  output  NBITS  latched ALU result.
- o_store_data  output  NBITS  latched store data.
- o_pc_plus8  output  NBITS  latched link address.
- o_reg_write  output  1  latched, qualified register write.
- o_mem_read  output  1  latched load.
- o_mem_write  output  1  latched store.
- o_mem_to_reg  output  2  latched WB source.
- o_mem_width  output  2  latched width.
- o_mem_unsigned  output  1  latched sign control.
- o_halt  output  1  latched halt.

Behaviour:
- All outputs are registers; there is no combinational input-to-output path.
- Reset (async, high): every output is 0 immediately and held at 0 until reset deasserts. A bubble state is o_valid=0 with all controls 0.
- Latency: 1 clock. Inputs sampled at rising edge N appear on the outputs after edge N.
- Per-edge priority: reset > i_flush > i_stall > load.
- i_flush=1: o_valid, o_reg_write, o_mem_read, o_mem_write and o_halt are set to 0. o_mem_to_reg, o_mem_width and o_mem_unsigned are set to 0. Data fields (write_reg, alu_result, store_data, pc_plus8) are also set to 0. This applies regardless of i_stall.
- i_stall=1, i_flush=0: all outputs hold their previous value. Inputs are ignored.
- Load (neither asserted): all fields are copied, with these qualifications:
  - o_reg_write = i_reg_write & i_valid & (i_write_reg != 0). A write to $zero is suppressed, but o_write_reg still latches 0.
  - o_mem_read = i_mem_read & i_valid; o_mem_write = i_mem_write & i_valid; o_halt = i_halt & i_valid.
  - i_valid=0: the stage loads as a bubble. Data fields are still copied; all qualified controls are 0.
- i_mem_read and i_mem_write both 1 on a valid instruction is illegal. Both are latched as-is; the MEM stage gives write precedence.
- i_mem_to_reg=11 is reserved. It is latched unchanged.
- Reset asserted mid-stall or mid-flush: outputs go to 0 at once. The first edge after release performs a normal load.
- The block has no internal state beyond the output registers and no FSM. Stall/flush sequencing is owned by the hazard unit.

Test Plan:
- Reset: assert reset between clock edges → all outputs 0 before the next edge. Release, load i_write_reg=5'd31, i_pc_plus8=32'h0000_0048, i_reg_write=1, i_mem_to_reg=10, i_valid=1 → next edge o_write_reg=31, o_pc_plus8=0x48, o_reg_write=1.
- Basic pipelining: issue three back-to-back valid ALU ops with write_reg 8, 9, 10 and alu_result 0x11, 0x22, 0x33 → outputs follow exactly one cycle later, in order.
- Stall: load write_reg=12, alu_result=0xDEAD_BEEF, then hold i_stall=1 for 3 cycles while inputs change to 0x1234 → outputs stay 12 / 0xDEADBEEF for 3 cycles. Release → 0x1234 appears after the next edge.
- Flush priority: assert i_stall=1 and i_flush=1 together with valid store inputs (mem_write=1, store_data=0xCAFE) → o_valid=0, o_mem_write=0, o_store_data=0.
- $zero suppression: valid instruction with i_reg_write=1, i_write_reg=0 → o_reg_write=0, o_write_reg=0, o_valid=1. Same instruction with i_valid=0 → o_valid=0, o_mem_read=0, o_halt=0.
- Halt: valid i_halt=1 with i_alu_result=0x4 → o_halt=1 one cycle later. Same with i_valid=0 → o_halt=0.

Source files
------------

// File: rtl/ex_mem_latch.sv
// rtl/ex_mem_latch.sv - EX/MEM pipeline register with stall hold and flush bubble
//
// Purpose: captures the EX-stage destination register, ALU result, store data,
// link address and MEM/WB controls every clock. All outputs are registered.
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   i_stall, i_flush      hazard-unit hold / bubble requests (flush wins)
//   i_valid               EX stage holds a real instruction
//   i_write_reg .. i_halt EX-stage fields and controls to be latched
//   o_valid .. o_halt     latched fields; controls qualified by i_valid
module ex_mem_latch #(
    parameter int NBITS = 32,
    parameter int RBITS = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_stall,
    input  logic             i_flush,
    input  logic             i_valid,
    input  logic [RBITS-1:0] i_write_reg,
    input  logic [NBITS-1:0] i_alu_result,
    input  logic [NBITS-1:0] i_store_data,
    input  logic [NBITS-1:0] i_pc_plus8,
    input  logic             i_reg_write,
    input  logic             i_mem_read,
    input  logic             i_mem_write,
    input  logic [1:0]       i_mem_to_reg,
    input  logic [1:0]       i_mem_width,
    input  logic             i_mem_unsigned,
    input  logic             i_halt,
    output logic             o_valid,
    output logic [RBITS-1:0] o_write_reg,
    output logic [NBITS-1:0] o_alu_result,
    output logic [NBITS-1:0] o_store_data,
    output logic [NBITS-1:0] o_pc_plus8,
    output logic             o_reg_write,
    output logic             o_mem_read,
    output logic             o_mem_write,
    output logic [1:0]       o_mem_to_reg,
    output logic [1:0]       o_mem_width,
    output logic             o_mem_unsigned,
    output logic             o_halt
);

    logic             valid_q,        valid_d;
    logic [RBITS-1:0] write_reg_q,    write_reg_d;
    logic [NBITS-1:0] alu_result_q,   alu_result_d;
    logic [NBITS-1:0] store_data_q,   store_data_d;
    logic [NBITS-1:0] pc_plus8_q,     pc_plus8_d;
    logic             reg_write_q,    reg_write_d;
    logic             mem_read_q,     mem_read_d;
    logic             mem_write_q,    mem_write_d;
    logic [1:0]       mem_to_reg_q,   mem_to_reg_d;
    logic [1:0]       mem_width_q,    mem_width_d;
    logic             mem_unsigned_q, mem_unsigned_d;
    logic             halt_q,         halt_d;

    always_comb begin
        // Default: hold (stall behaviour)
        valid_d        = valid_q;
        write_reg_d    = write_reg_q;
        alu_result_d   = alu_result_q;
        store_data_d   = store_data_q;
        pc_plus8_d     = pc_plus8_q;
        reg_write_d    = reg_write_q;
        mem_read_d     = mem_read_q;
        mem_write_d    = mem_write_q;
        mem_to_reg_d   = mem_to_reg_q;
        mem_width_d    = mem_width_q;
        mem_unsigned_d = mem_unsigned_q;
        halt_d         = halt_q;

        if (i_flush) begin
            // Full bubble: data fields cleared too, so a flushed slot is all zero
            valid_d        = 1'b0;
            write_reg_d    = '0;
            alu_result_d   = '0;
            store_data_d   = '0;
            pc_plus8_d     = '0;
            reg_write_d    = 1'b0;
            mem_read_d     = 1'b0;
            mem_write_d    = 1'b0;
            mem_to_reg_d   = 2'b00;
            mem_width_d    = 2'b00;
            mem_unsigned_d = 1'b0;
            halt_d         = 1'b0;
        end else if (!i_stall) begin
            valid_d        = i_valid;
            write_reg_d    = i_write_reg;
            alu_result_d   = i_alu_result;
            store_data_d   = i_store_data;
            pc_plus8_d     = i_pc_plus8;
            // Writes to $zero are dropped here so WB never needs to check
            reg_write_d    = i_reg_write & i_valid & (i_write_reg != '0);
            mem_read_d     = i_mem_read & i_valid;
            mem_write_d    = i_mem_write & i_valid;
            mem_to_reg_d   = i_mem_to_reg;
            mem_width_d    = i_mem_width;
            mem_unsigned_d = i_mem_unsigned;
            halt_d         = i_halt & i_valid;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q        <= 1'b0;
            write_reg_q    <= '0;
            alu_result_q   <= '0;
            store_data_q   <= '0;
            pc_plus8_q     <= '0;
            reg_write_q    <= 1'b0;
            mem_read_q     <= 1'b0;
            mem_write_q    <= 1'b0;
            mem_to_reg_q   <= 2'b00;
            mem_width_q    <= 2'b00;
            mem_unsigned_q <= 1'b0;
            halt_q         <= 1'b0;
        end else begin
            valid_q        <= valid_d;
            write_reg_q    <= write_reg_d;
            alu_result_q   <= alu_result_d;
            store_data_q   <= store_data_d;
            pc_plus8_q     <= pc_plus8_d;
            reg_write_q    <= reg_write_d;
            mem_read_q     <= mem_read_d;
            mem_write_q    <= mem_write_d;
            mem_to_reg_q   <= mem_to_reg_d;
            mem_width_q    <= mem_width_d;
            mem_unsigned_q <= mem_unsigned_d;
            halt_q         <= halt_d;
        end
    end

    assign o_valid        = valid_q;
    assign o_write_reg    = write_reg_q;
    assign o_alu_result   = alu_result_q;
    assign o_store_data   = store_data_q;
    assign o_pc_plus8     = pc_plus8_q;
    assign o_reg_write    = reg_write_q;
    assign o_mem_read     = mem_read_q;
    assign o_mem_write    = mem_write_q;
    assign o_mem_to_reg   = mem_to_reg_q;
    assign o_mem_width    = mem_width_q;
    assign o_mem_unsigned = mem_unsigned_q;
    assign o_halt         = halt_q;

endmodule

// File: tb/tb_ex_mem_latch.sv
// tb/tb_ex_mem_latch.sv - directed self-checking bench for ex_mem_latch
module tb_ex_mem_latch;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_stall, i_flush, i_valid;
    logic [4:0]  i_write_reg;
    logic [31:0] i_alu_result, i_store_data, i_pc_plus8;
    logic        i_reg_write, i_mem_read, i_mem_write;
    logic [1:0]  i_mem_to_reg, i_mem_width;
    logic        i_mem_unsigned, i_halt;
    logic        o_valid;
    logic [4:0]  o_write_reg;
    logic [31:0] o_alu_result, o_store_data, o_pc_plus8;
    logic        o_reg_write, o_mem_read, o_mem_write;
    logic [1:0]  o_mem_to_reg, o_mem_width;
    logic        o_mem_unsigned, o_halt;

    int tests_run    = 0;
    int tests_failed = 0;

    ex_mem_latch #(.NBITS(32), .RBITS(5)) dut (
        .clk            (clk),
        .reset          (reset),
        .i_stall        (i_stall),
        .i_flush        (i_flush),
        .i_valid        (i_valid),
        .i_write_reg    (i_write_reg),
        .i_alu_result   (i_alu_result),
        .i_store_data   (i_store_data),
        .i_pc_plus8     (i_pc_plus8),
        .i_reg_write    (i_reg_write),
        .i_mem_read     (i_mem_read),
        .i_mem_write    (i_mem_write),
        .i_mem_to_reg   (i_mem_to_reg),
        .i_mem_width    (i_mem_width),
        .i_mem_unsigned (i_mem_unsigned),
        .i_halt         (i_halt),
        .o_valid        (o_valid),
        .o_write_reg    (o_write_reg),
        .o_alu_result   (o_alu_result),
        .o_store_data   (o_store_data),
        .o_pc_plus8     (o_pc_plus8),
        .o_reg_write    (o_reg_write),
        .o_mem_read     (o_mem_read),
        .o_mem_write    (o_mem_write),
        .o_mem_to_reg   (o_mem_to_reg),
        .o_mem_width    (o_mem_width),
        .o_mem_unsigned (o_mem_unsigned),
        .o_halt         (o_halt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_stall = 0; i_flush = 0; i_valid = 0;
        i_write_reg = 0; i_alu_result = 0; i_store_data = 0; i_pc_plus8 = 0;
        i_reg_write = 0; i_mem_read = 0; i_mem_write = 0;
        i_mem_to_reg = 0; i_mem_width = 0; i_mem_unsigned = 0; i_halt = 0;
    endtask

    logic [4:0]  pipe_reg [3] = '{5'd8, 5'd9, 5'd10};
    logic [31:0] pipe_alu [3] = '{32'h11, 32'h22, 32'h33};

    initial begin
        idle_inputs();
        reset = 1;
        #2;
        check_eq("reset_valid", {31'd0, o_valid}, 32'd0);
        check_eq("reset_alu", o_alu_result, 32'd0);
        tick(); tick();
        reset = 0;

        // Load something nonzero, then assert reset between edges
        i_valid = 1; i_reg_write = 1; i_write_reg = 5'd3; i_alu_result = 32'hA5A5;
        i_mem_width = 2'b11; i_mem_unsigned = 1;
        tick();
        check_eq("pre_reset_alu", o_alu_result, 32'hA5A5);
        #2 reset = 1;
        #1;
        check_eq("async_reset_alu", o_alu_result, 32'd0);
        check_eq("async_reset_wreg", {27'd0, o_write_reg}, 32'd0);
        check_eq("async_reset_rw", {31'd0, o_reg_write}, 32'd0);
        check_eq("async_reset_width", {30'd0, o_mem_width}, 32'd0);
        tick();
        reset = 0;

        // First load after release: JAL link write to $31
        idle_inputs();
        i_valid = 1; i_write_reg = 5'd31; i_pc_plus8 = 32'h48; i_reg_write = 1; i_mem_to_reg = 2'b10;
        tick();
        check_eq("link_wreg", {27'd0, o_write_reg}, 32'd31);
        check_eq("link_pc8", o_pc_plus8, 32'h48);
        check_eq("link_rw", {31'd0, o_reg_write}, 32'd1);
        check_eq("link_m2r", {30'd0, o_mem_to_reg}, 32'd2);

        // Back-to-back pipelining
        for (int k = 0; k < 3; k++) begin
            idle_inputs();
            i_valid = 1; i_reg_write = 1; i_write_reg = pipe_reg[k]; i_alu_result = pipe_alu[k];
            tick();
            check_eq($sformatf("pipe%0d_wreg", k), {27'd0, o_write_reg}, {27'd0, pipe_reg[k]});
            check_eq($sformatf("pipe%0d_alu", k), o_alu_result, pipe_alu[k]);
        end

        // Stall holds for three cycles
        idle_inputs();
        i_valid = 1; i_reg_write = 1; i_write_reg = 5'd12; i_alu_result = 32'hDEAD_BEEF;
        tick();
        i_stall = 1; i_alu_result = 32'h1234; i_write_reg = 5'd13;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_eq($sformatf("stall%0d_alu", k), o_alu_result, 32'hDEAD_BEEF);
            check_eq($sformatf("stall%0d_wreg", k), {27'd0, o_write_reg}, 32'd12);
        end
        i_stall = 0;
        tick();
        check_eq("unstall_alu", o_alu_result, 32'h1234);

        // Flush beats stall
        idle_inputs();
        i_stall = 1; i_flush = 1; i_valid = 1; i_mem_write = 1; i_store_data = 32'hCAFE;
        i_write_reg = 5'd7; i_mem_width = 2'b11;
        tick();
        check_eq("flush_valid", {31'd0, o_valid}, 32'd0);
        check_eq("flush_mw", {31'd0, o_mem_write}, 32'd0);
        check_eq("flush_sdata", o_store_data, 32'd0);
        check_eq("flush_alu", o_alu_result, 32'd0);
        check_eq("flush_width", {30'd0, o_mem_width}, 32'd0);

        // Store without flush latches store data
        i_stall = 0; i_flush = 0;
        tick();
        check_eq("store_mw", {31'd0, o_mem_write}, 32'd1);
        check_eq("store_sdata", o_store_data, 32'hCAFE);

        // $zero suppression
        idle_inputs();
        i_valid = 1; i_reg_write = 1; i_write_reg = 5'd0; i_mem_read = 1;
        tick();
        check_eq("zero_rw", {31'd0, o_reg_write}, 32'd0);
        check_eq("zero_wreg", {27'd0, o_write_reg}, 32'd0);
        check_eq("zero_valid", {31'd0, o_valid}, 32'd1);
        check_eq("zero_mr", {31'd0, o_mem_read}, 32'd1);
        i_valid = 0;
        tick();
        check_eq("bubble_valid", {31'd0, o_valid}, 32'd0);
        check_eq("bubble_mr", {31'd0, o_mem_read}, 32'd0);
        check_eq("bubble_halt", {31'd0, o_halt}, 32'd0);

        // Halt qualification
        idle_inputs();
        i_valid = 1; i_halt = 1; i_alu_result = 32'h4;
        tick();
        check_eq("halt_valid", {31'd0, o_halt}, 32'd1);
        check_eq("halt_alu", o_alu_result, 32'h4);
        i_valid = 0;
        tick();
        check_eq("halt_bubble", {31'd0, o_halt}, 32'd0);
        check_eq("halt_bubble_alu", o_alu_result, 32'h4);

        // Reserved mem_to_reg latched unchanged; valid write to nonzero reg
        idle_inputs();
        i_valid = 1; i_reg_write = 1; i_write_reg = 5'd1; i_mem_to_reg = 2'b11;
        tick();
        check_eq("m2r_reserved", {30'd0, o_mem_to_reg}, 32'd3);
        check_eq("rw_reg1", {31'd0, o_reg_write}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
